// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the alu_resp command responder.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_shift1.sv
// Combinational one-bit right shifter; i_arith replicates the MSB, otherwise zero-fills.
module alu_shift1 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_arith,
    output logic [WIDTH-1:0] o_data
);

    assign o_data = {i_arith & i_data[WIDTH-1], i_data[WIDTH-1:1]};

endmodule

// File: rtl/alu_resp.sv
// Multi-cycle ALU responder: add/sub in one cycle, shifts one bit per cycle, valid/ready on both sides.
// Optional zero/ovf flag outputs are built when ALU_RESP_FLAGS_EN is defined.
module alu_resp
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SHW   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [SHW-1:0]   inC,
    input  logic [1:0]       op,
    output logic             resp_valid,
    input  logic             resp_ready,
`ifdef ALU_RESP_FLAGS_EN
    output logic             zero,
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] ans
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_ans;
    logic [WIDTH-1:0] w_ans_nxt;
    logic [SHW-1:0]   r_cnt;
    logic [SHW-1:0]   w_cnt_nxt;
    logic             r_arith;
    logic             w_arith_nxt;
    logic             w_accept;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_shifted;

    assign req_ready  = (r_state == IDLE) && reset;
    assign resp_valid = (r_state == DONE);
    assign ans        = r_ans;
    assign w_accept   = req_valid && req_ready;
    assign w_sum      = inA + inB;
    assign w_diff     = inA - inB;

    alu_shift1 #(
        .WIDTH (WIDTH)
    ) u_shift1 (
        .i_data  (r_ans),
        .i_arith (r_arith),
        .o_data  (w_shifted)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ans   <= '0;
            r_cnt   <= '0;
            r_arith <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ans   <= w_ans_nxt;
            r_cnt   <= w_cnt_nxt;
            r_arith <= w_arith_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ans_nxt   = r_ans;
        w_cnt_nxt   = r_cnt;
        w_arith_nxt = r_arith;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_arith_nxt = (op == OP_SRA);
                    if (op == OP_ADD) begin
                        w_ans_nxt   = w_sum;
                        w_state_nxt = DONE;
                    end else if (op == OP_SUB) begin
                        w_ans_nxt   = w_diff;
                        w_state_nxt = DONE;
                    end else begin
                        w_ans_nxt = inA;
                        if (inC == '0) begin
                            w_state_nxt = DONE;
                        end else begin
                            w_cnt_nxt   = inC;
                            w_state_nxt = SHIFT;
                        end
                    end
                end
            end
            SHIFT: begin
                w_ans_nxt = w_shifted;
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == SHW'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef ALU_RESP_FLAGS_EN
    logic r_zero;
    logic r_ovf;
    logic w_add_ovf;
    logic w_sub_ovf;

    // Two's-complement overflow: operand signs agree (add) or differ (sub) and the result sign flips.
    assign w_add_ovf = (inA[WIDTH-1] == inB[WIDTH-1]) && (w_sum[WIDTH-1] != inA[WIDTH-1]);
    assign w_sub_ovf = (inA[WIDTH-1] != inB[WIDTH-1]) && (w_diff[WIDTH-1] != inA[WIDTH-1]);
    assign zero      = r_zero;
    assign ovf       = r_ovf;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (op == OP_ADD) begin
                    r_ovf <= w_add_ovf;
                end else if (op == OP_SUB) begin
                    r_ovf <= w_sub_ovf;
                end else begin
                    r_ovf <= 1'b0;
                end
            end
            if ((w_state_nxt == DONE) && (r_state != DONE)) begin
                r_zero <= (w_ans_nxt == '0);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_resp.sv
// Directed-vector bench for alu_resp; flag checks are included when ALU_RESP_FLAGS_EN is defined.
module tb_alu_resp;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] inA;
    logic [3:0] inB;
    logic [1:0] inC;
    logic [1:0] op;
    logic       resp_valid;
    logic       resp_ready;
    logic [3:0] ans;
`ifdef ALU_RESP_FLAGS_EN
    logic       zero;
    logic       ovf;
`endif

    int n_chk;
    int n_err;

    alu_resp #(
        .WIDTH (4),
        .SHW   (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .inA        (inA),
        .inB        (inB),
        .inC        (inC),
        .op         (op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
`ifdef ALU_RESP_FLAGS_EN
        .zero       (zero),
        .ovf        (ovf),
`endif
        .ans        (ans)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] c;
        logic [1:0] op;
        logic [3:0] exp_ans;
        int         exp_lat;
        logic       exp_zero;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        string tag;
        tag = $sformatf("v%0d", idx);
        inA = v.a;
        inB = v.b;
        inC = v.c;
        op  = v.op;
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        #1;
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        inA = ~v.a;
        inB = ~v.b;
        inC = ~v.c;
        op  = ~v.op;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, "_ans"}, 32'(ans), 32'(v.exp_ans));
`ifdef ALU_RESP_FLAGS_EN
        chk({tag, "_zero"}, 32'(zero), 32'(v.exp_zero));
        chk({tag, "_ovf"}, 32'(ovf), 32'(v.exp_ovf));
`endif
        step();
        chk({tag, "_resp_drop"}, 32'(resp_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_ans_hold"}, 32'(ans), 32'(v.exp_ans));
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        vecs[0]  = '{4'b1000, 4'b0000, 2'd1, 2'b00, 4'b1000, 1, 1'b0, 1'b0};
        vecs[1]  = '{4'b0011, 4'b0101, 2'd0, 2'b01, 4'b1110, 1, 1'b0, 1'b0};
        vecs[2]  = '{4'b1000, 4'b0000, 2'd1, 2'b11, 4'b1100, 2, 1'b0, 1'b0};
        vecs[3]  = '{4'b1000, 4'b0000, 2'd3, 2'b10, 4'b0001, 4, 1'b0, 1'b0};
        vecs[4]  = '{4'b1000, 4'b0000, 2'd0, 2'b10, 4'b1000, 1, 1'b0, 1'b0};
        vecs[5]  = '{4'b0111, 4'b0001, 2'd0, 2'b00, 4'b1000, 1, 1'b0, 1'b1};
        vecs[6]  = '{4'b1111, 4'b0001, 2'd0, 2'b00, 4'b0000, 1, 1'b1, 1'b0};
        vecs[7]  = '{4'b1010, 4'b0000, 2'd3, 2'b11, 4'b1111, 4, 1'b0, 1'b0};
        vecs[8]  = '{4'b0000, 4'b0001, 2'd0, 2'b01, 4'b1111, 1, 1'b0, 1'b0};
        vecs[9]  = '{4'b1111, 4'b0000, 2'd2, 2'b10, 4'b0011, 3, 1'b0, 1'b0};
        vecs[10] = '{4'b0001, 4'b0000, 2'd1, 2'b11, 4'b0000, 2, 1'b1, 1'b0};
        vecs[11] = '{4'b1000, 4'b0001, 2'd0, 2'b01, 4'b0111, 1, 1'b0, 1'b1};

        reset      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        inA = '0;
        inB = '0;
        inC = '0;
        op  = '0;
        step();
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_ans", 32'(ans), 32'd0);
`ifdef ALU_RESP_FLAGS_EN
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        reset = 1'b1;
        #1;
        chk("rst_release_ready", 32'(req_ready), 32'd1);
        step();

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: response held for 3 cycles while a second command waits.
        inA = 4'b0010;
        inB = 4'b0011;
        inC = 2'd0;
        op  = 2'b00;
        req_valid  = 1'b1;
        resp_ready = 1'b0;
        step();
        inA = 4'b0001;
        inB = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp%0d_resp_valid", k), 32'(resp_valid), 32'd1);
            chk($sformatf("bp%0d_ans", k), 32'(ans), 32'd5);
            chk($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'd0);
            step();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_ready_in_done", 32'(req_ready), 32'd0);
        step();
        chk("bp_handshake_drop", 32'(resp_valid), 32'd0);
        chk("bp_handshake_ans", 32'(ans), 32'd5);
        chk("bp_reaccept_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        chk("bp_second_valid", 32'(resp_valid), 32'd1);
        chk("bp_second_ans", 32'(ans), 32'd2);
        step();
        chk("bp_second_drop", 32'(resp_valid), 32'd0);

        // Reset asserted during the second SHIFT cycle aborts the command.
        inA = 4'b1000;
        inB = 4'b0000;
        inC = 2'd3;
        op  = 2'b10;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("mid_first_shift", 32'(ans), 32'b0100);
        reset = 1'b0;
        step();
        chk("mid_rst_ans", 32'(ans), 32'd0);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("mid_rel_req_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("mid_no_stale%0d", k), 32'(resp_valid), 32'd0);
        end
        chk("mid_final_ans", 32'(ans), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_resp.md
Name: alu_resp

Overview:
- Multi-cycle ALU command responder.
- Accepts one command (operands A, B, shift count C, opcode) over a valid/ready request handshake.
- Computes the result: add/sub in one cycle; shifts iterate one bit per cycle.
- Returns the result over a valid/ready response handshake.
- Serves as the target end for stimulus/initiator blocks and datapath sequencers that previously drove a purely combinational ALU.

Parameters:
- WIDTH, 4, operand/result width in bits.
- SHW, 2, shift-count width; max shift = 2^SHW-1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- req_valid  input  1  command present
- req_ready  output  1  responder can accept a command
- inA  input  WIDTH  operand A
- inB  input  WIDTH  operand B
- inC  input  SHW  shift count
- op  input  2  opcode: 00 add, 01 sub, 10 logical shift right A by C, 11 arithmetic shift right A by C
- resp_valid  output  1  result valid
- resp_ready  input  1  consumer accepts result
- ans  output  WIDTH  result, registered

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, ans=0, resp_valid=0, internal counter=0.
  - req_ready=0 while reset is low.
  - Reset mid-operation aborts the command; no response is issued for it.
- req_ready = (state==IDLE) && reset, combinational from registered state.
- States:
  - IDLE: on req_valid&&req_ready, latch inA/inB/inC/op.
    - op 00/01: ans <= A+B or A-B (mod 2^WIDTH, carry/borrow discarded); next state DONE.
    - op 10/11 with C==0: ans <= A; next state DONE.
    - op 10/11 with C!=0: ans <= A; cnt <= C; next state SHIFT.
  - SHIFT: each cycle ans shifts right by 1 (fill 0 for op 10, fill ans[MSB] for op 11); cnt decrements. When cnt==1, the final shift occurs and next state is DONE.
  - DONE: resp_valid=1, ans held stable. On resp_ready, go to IDLE; resp_valid drops next cycle.
- Latency (acceptance edge to resp_valid high):
  - add/sub/shift-by-0: 1 cycle.
  - shift by n: n+1 cycles.
- Ordering rules:
  - No same-cycle accept of a new command while in DONE; the earliest re-accept is the cycle after the response handshake.
  - Inputs are sampled only at acceptance; later changes on inA/inB/inC/op are ignored.
- resp_ready high in IDLE/SHIFT has no effect.
- ans holds its last value after the handshake until the next command is accepted.

Optional Feature:
- Macro ALU_RESP_FLAGS_EN.
- When defined, adds outputs zero (1) and ovf (1), both registered and updated with ans:
  - zero = (final ans==0).
  - ovf = signed overflow for add/sub; 0 for shifts.
  - Both reset to 0 and are valid when resp_valid is high.
- When undefined, the ports are absent and the logic is removed.

Decomposition:
- Shared package alu_pkg: opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_SRL=2'b10, OP_SRA=2'b11; state encoding IDLE/SHIFT/DONE.
- One natural sub-module: alu_shift1, a combinational single-bit right shifter with an arithmetic/logical select, instantiated in the SHIFT datapath.

Test Plan:
- Add: A=4'b1000, B=0, C=1, op=00, resp_ready=1 -> resp_valid 1 cycle after accept, ans=4'b1000, back in IDLE next cycle.
- Sub wrap: A=4'b0011, B=4'b0101, op=01 -> ans=4'b1110; with flags enabled, ovf=0, zero=0.
- Shifts, A=4'b1000, C=1:
  - op=11 -> ans=4'b1100 after 2 cycles.
  - op=10 with C=3 -> ans=4'b0001 after 4 cycles.
  - C=0 -> ans=4'b1000 after 1 cycle.
- Backpressure: hold resp_ready=0 for 3 cycles in DONE -> resp_valid and ans stable, req_ready=0. A command presented during that time is not accepted; it is accepted the cycle after resp_ready goes high.
- Reset mid-shift: op=10, C=3, drive reset=0 during the 2nd SHIFT cycle -> next cycle ans=0, resp_valid=0. req_ready=1 once reset returns high; no stale response.
- Flags, ALU_RESP_FLAGS_EN defined: A=4'b0111, B=4'b0001, op=00 -> ans=4'b1000, ovf=1, zero=0.
